// File: rtl/cxu_flow_adapter_pkg.sv
// cxu_flow_adapter_pkg: shared parameter checks (common_pkg) and CXU status types (cxu_pkg)
package common_pkg;
    function automatic bit check_param_2(input int v);
        return v == 32 || v == 64;
    endfunction
    function automatic bit check_param_pos(input int v);
        return v > 0;
    endfunction
    function automatic bit check_param_range(input int v, input int lo, input int hi);
        return v >= lo && v <= hi;
    endfunction
    function automatic bit check_param_pos2exp(input int v);
        return v > 0 && (v & (v - 1)) == 0;
    endfunction
endpackage

package cxu_pkg;
    import common_pkg::*;
    localparam int Status_w = 3;
    typedef enum logic [Status_w-1:0] {
        CX_OK = 0,
        CX_ERROR_ALL,
        CX_ERROR_CUSTOM,
        CX_ERROR_STATE,
        CX_ERROR_OFF_STATE,
        CX_ERROR_FUNC,
        CX_ERROR_OP
    } cx_status_e;
endpackage

// File: rtl/cxu_flow_adapter_sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers
// ports: clk, rst (sync, active high); wr_v/wr_data push; rd_rdy pops the head;
//        rd_v/rd_data present the head; full/empty status
module sync_fifo #(
    parameter int W = 8,
    parameter int Depth = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_v,
    input  logic [W-1:0] wr_data,
    input  logic         rd_rdy,
    output logic         rd_v,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int Aw = $clog2(Depth);
    logic [W-1:0] mem [Depth];
    logic [Aw:0] wp, rp;
    logic wr_en, rd_en;
    assign empty = wp == rp;
    assign full = (wp[Aw] != rp[Aw]) && (wp[Aw-1:0] == rp[Aw-1:0]);
    assign rd_v = !empty;
    assign rd_data = mem[rp[Aw-1:0]];
    assign rd_en = rd_rdy && !empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO is accepted then
    assign wr_en = wr_v && (!full || rd_en);
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (rd_en) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wp[Aw-1:0]] <= wr_data;
    end
endmodule

// File: rtl/cxu_flow_adapter.sv
// cxu_flow_adapter: flow-controlled req/resp front end for a fixed-latency, non-stallable CXU
// ports: clk, rst (sync, active high)
//        req_*        CPU request channel (valid/ready, func, two operands)
//        resp_*       CPU response channel (valid/ready, status, data) from the FIFO head
//        cxu_req_*    issue to the CXU (valid = accepted request, rest passthrough)
//        cxu_resp_*   CXU result, arriving exactly Latency cycles after issue
//        err          sticky protocol error
module cxu_flow_adapter
    import common_pkg::*;
    import cxu_pkg::*;
#(
    parameter int Xlen = 32,
    parameter int Func_id_w = 10,
    parameter int Latency = 2,
    parameter int Depth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [Func_id_w-1:0] req_func,
    input  logic [Xlen-1:0]      req_data0,
    input  logic [Xlen-1:0]      req_data1,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [Status_w-1:0]  resp_status,
    output logic [Xlen-1:0]      resp_data,
    output logic                 cxu_req_valid,
    output logic [Func_id_w-1:0] cxu_req_func,
    output logic [Xlen-1:0]      cxu_req_data0,
    output logic [Xlen-1:0]      cxu_req_data1,
    input  logic                 cxu_resp_valid,
    input  logic [Status_w-1:0]  cxu_resp_status,
    input  logic [Xlen-1:0]      cxu_resp_data,
    output logic                 err
);
    localparam int Cw = $clog2(Depth) + 1;
    typedef struct packed {
        logic [Status_w-1:0] status;
        logic [Xlen-1:0]     data;
    } resp_t;

    if (!check_param_2(Xlen)) begin : g_bad_xlen
        $error("Xlen must be 32 or 64");
    end
    if (!check_param_pos(Func_id_w)) begin : g_bad_func
        $error("Func_id_w must be positive");
    end
    if (!check_param_range(Latency, 1, 8)) begin : g_bad_latency
        $error("Latency must be in [1,8]");
    end
    if (!check_param_pos2exp(Depth)) begin : g_bad_depth
        $error("Depth must be a positive power of two");
    end

    logic [Cw-1:0] credits;
    logic [Latency-1:0] inflight;
    logic req_hs, resp_hs, full, empty, head_v;
    resp_t wr_entry, head;

    // credits cover in-flight ops plus queued entries, so a result always finds a free slot
    assign req_ready = !rst && credits < Cw'(Depth);
    assign req_hs = req_valid && req_ready;
    assign resp_valid = head_v;
    assign resp_hs = resp_valid && resp_ready;
    assign cxu_req_valid = req_hs;
    assign cxu_req_func = req_func;
    assign cxu_req_data0 = req_data0;
    assign cxu_req_data1 = req_data1;
    assign wr_entry = {cxu_resp_status, cxu_resp_data};
    assign resp_status = empty ? '0 : head.status;
    assign resp_data = empty ? '0 : head.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= '0;
            inflight <= '0;
            err <= 1'b0;
        end else begin
            credits <= credits + Cw'(req_hs) - Cw'(resp_hs);
            inflight <= (inflight << 1) | Latency'(req_hs);
            // a result must line up with the tracked issue slot and must find room
            if (cxu_resp_valid != inflight[Latency-1] || (cxu_resp_valid && full && !resp_hs))
                err <= 1'b1;
        end
    end

    sync_fifo #(.W(Status_w + Xlen), .Depth(Depth)) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr_v(cxu_resp_valid),
        .wr_data(wr_entry),
        .rd_rdy(resp_ready),
        .rd_v(head_v),
        .rd_data(head),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_cxu_flow_adapter.sv
// tb_cxu_flow_adapter: directed self-checking bench with a 2-cycle adder CXU model
module tb_cxu_flow_adapter;
    import cxu_pkg::*;
    localparam int Xlen = 32;
    localparam int Fw = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic resp_ready = 1'b0;
    logic inject = 1'b0;
    logic [Fw-1:0] req_func = '0;
    logic [Xlen-1:0] req_data0 = '0;
    logic [Xlen-1:0] req_data1 = '0;
    logic req_ready, resp_valid, cxu_req_valid, cxu_resp_valid, err;
    logic [Status_w-1:0] resp_status, cxu_resp_status;
    logic [Xlen-1:0] resp_data, cxu_req_data0, cxu_req_data1, cxu_resp_data;
    logic [Fw-1:0] cxu_req_func;

    logic [1:0] pipe_v = '0;
    logic [Xlen-1:0] pipe_d0 = '0, pipe_d1 = '0;
    logic [2:0] pipe_s0 = '0, pipe_s1 = '0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // external CXU: sum of operands, status CX_ERROR_FUNC for func 0x3ff; not reset by rst
    always @(posedge clk) begin
        pipe_v <= {pipe_v[0], cxu_req_valid};
        pipe_d0 <= cxu_req_data0 + cxu_req_data1;
        pipe_d1 <= pipe_d0;
        pipe_s0 <= (cxu_req_func == 10'h3ff) ? 3'd5 : 3'd0;
        pipe_s1 <= pipe_s0;
    end
    assign cxu_resp_valid = pipe_v[1] | inject;
    assign cxu_resp_data = pipe_d1;
    assign cxu_resp_status = pipe_s1;

    cxu_flow_adapter #(.Xlen(Xlen), .Func_id_w(Fw), .Latency(2), .Depth(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_status(resp_status), .resp_data(resp_data),
        .cxu_req_valid(cxu_req_valid), .cxu_req_func(cxu_req_func),
        .cxu_req_data0(cxu_req_data0), .cxu_req_data1(cxu_req_data1),
        .cxu_resp_valid(cxu_resp_valid), .cxu_resp_status(cxu_resp_status),
        .cxu_resp_data(cxu_resp_data), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks += 5;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", err); end
        if (resp_data !== 32'd0) begin failures++; $display("FAIL reset_resp_data got %0h want 0", resp_data); end
        if (resp_status !== 3'd0) begin failures++; $display("FAIL reset_resp_status got %0d want 0", resp_status); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_single_op();
        tick();
        req_valid = 1'b1; req_func = 10'd1; req_data0 = 32'd5; req_data1 = 32'd7;
        @(negedge clk);
        checks += 4;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL single_req_ready got %b want 1", req_ready); end
        if (cxu_req_valid !== 1'b1) begin failures++; $display("FAIL single_cxu_valid got %b want 1", cxu_req_valid); end
        if (cxu_req_data0 !== 32'd5) begin failures++; $display("FAIL single_passthru_d0 got %0d want 5", cxu_req_data0); end
        if (cxu_req_func !== 10'd1) begin failures++; $display("FAIL single_passthru_func got %0d want 1", cxu_req_func); end
        tick();
        req_valid = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== (n == 3)) begin failures++; $display("FAIL single_resp_valid_t%0d got %b want %b", n, resp_valid, n == 3); end
        end
        checks += 2;
        if (resp_data !== 32'd12) begin failures++; $display("FAIL single_resp_data got %0d want 12", resp_data); end
        if (resp_status !== 3'd0) begin failures++; $display("FAIL single_resp_status got %0d want 0", resp_status); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        @(negedge clk);
        checks += 2;
        if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_drained got %b want 0", resp_valid); end
        if (err !== 1'b0) begin failures++; $display("FAIL single_err got %b want 0", err); end
    endtask

    task automatic test_back_pressure();
        int acc = 0;
        tick();
        resp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_data0 = 32'd10 + acc; req_data1 = 32'd0;
            req_func = (acc == 1) ? 10'h3ff : 10'd0;
            @(negedge clk);
            checks++;
            if (req_ready !== (i < 4)) begin failures++; $display("FAIL bp_req_ready_c%0d got %b want %b", i, req_ready, i < 4); end
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        checks++;
        if (acc != 4) begin failures++; $display("FAIL bp_accepted got %0d want 4", acc); end
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_full_req_ready got %b want 0", req_ready); end
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks += 3;
            if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_resp_valid_%0d got %b want 1", k, resp_valid); end
            if (resp_data !== 32'd10 + k) begin failures++; $display("FAIL bp_resp_data_%0d got %0d want %0d", k, resp_data, 10 + k); end
            if (resp_status !== ((k == 1) ? 3'd5 : 3'd0)) begin failures++; $display("FAIL bp_resp_status_%0d got %0d want %0d", k, resp_status, (k == 1) ? 5 : 0); end
            tick();
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_reassert got %b want 1", req_ready); end
            end
        end
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got %b want 0", resp_valid); end
    endtask

    task automatic test_streaming();
        logic [31:0] val = 0;
        logic [31:0] want;
        tick();
        exp_q.delete();
        resp_ready = 1'b1;
        req_valid = 1'b1;
        req_func = 10'd2;
        for (int c = 0; c < 100; c++) begin
            req_data0 = val; req_data1 = 32'd100;
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1) begin failures++; $display("FAIL stream_req_ready_c%0d got %b want 1", c, req_ready); end
            if (c >= 3) begin
                checks++;
                if (resp_valid !== 1'b1) begin failures++; $display("FAIL stream_resp_valid_c%0d got %b want 1", c, resp_valid); end
            end
            if (req_ready) begin exp_q.push_back(val + 100); val++; end
            if (resp_valid) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
                checks++;
                if (resp_data !== want) begin failures++; $display("FAIL stream_data_c%0d got %0d want %0d", c, resp_data, want); end
            end
            tick();
        end
        req_valid = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                want = exp_q.pop_front();
                checks++;
                if (resp_data !== want) begin failures++; $display("FAIL stream_drain_data got %0d want %0d", resp_data, want); end
            end
            tick();
        end
        resp_ready = 1'b0;
        @(negedge clk);
        checks += 3;
        if (exp_q.size() != 0) begin failures++; $display("FAIL stream_missing got %0d want 0", exp_q.size()); end
        if (resp_valid !== 1'b0) begin failures++; $display("FAIL stream_extra got %b want 0", resp_valid); end
        if (err !== 1'b0) begin failures++; $display("FAIL stream_err got %b want 0", err); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int got = 0;
        logic [31:0] want;
        tick();
        for (int c = 0; c < 300 && got < 13; c++) begin
            req_valid = (sent < 13);
            req_data0 = 32'd1000 + sent; req_data1 = sent;
            resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (req_valid && req_ready) sent++;
            if (resp_valid && resp_ready) begin
                want = 32'd1000 + 2 * got;
                checks++;
                if (resp_data !== want) begin failures++; $display("FAIL wrap_data_%0d got %0d want %0d", got, resp_data, want); end
                got++;
            end
            tick();
        end
        req_valid = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        checks += 3;
        if (got != 13) begin failures++; $display("FAIL wrap_count got %0d want 13", got); end
        if (resp_valid !== 1'b0) begin failures++; $display("FAIL wrap_extra got %b want 0", resp_valid); end
        if (err !== 1'b0) begin failures++; $display("FAIL wrap_err got %b want 0", err); end
    endtask

    task automatic test_protocol_err();
        tick();
        inject = 1'b1;
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL perr_same_cycle got %b want 0", err); end
        tick();
        inject = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL perr_set got %b want 1", err); end
        repeat (5) tick();
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL perr_sticky got %b want 1", err); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (err !== 1'b0) begin failures++; $display("FAIL perr_cleared got %b want 0", err); end
        if (resp_valid !== 1'b0) begin failures++; $display("FAIL perr_fifo_cleared got %b want 0", resp_valid); end
        if (req_ready !== 1'b1) begin failures++; $display("FAIL perr_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_reset_midflight();
        tick();
        resp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_data0 = 32'd20 + i; req_data1 = 32'd0;
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_req_ready_%0d got %b want 1", i, req_ready); end
            tick();
        end
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks += 2;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_req_ready got %b want 0", req_ready); end
        if (resp_valid !== 1'b1) begin failures++; $display("FAIL mid_queued_before_rst got %b want 1", resp_valid); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (resp_valid !== 1'b0) begin failures++; $display("FAIL mid_resp_valid got %b want 0", resp_valid); end
        if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_req_ready got %b want 1", req_ready); end
        if (err !== 1'b0) begin failures++; $display("FAIL mid_err_early got %b want 0", err); end
        tick();
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL mid_stale_err got %b want 1", err); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_back_pressure();
        test_streaming();
        test_wrap();
        test_protocol_err();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cxu_flow_adapter.md
Name: cxu_flow_adapter

Overview:
- Wraps a fixed-latency, non-stallable pipelined CXU (custom function unit) so the CPU can drive it through a flow-controlled request/response interface.
- Requests pass straight through to the CXU. CXU results land in a response FIFO that the CPU drains with resp_valid/resp_ready.
- Credit accounting throttles req_ready so a response never arrives at a full FIFO.
- Sits between the CPU's CXU port and each fixed-latency CXU in the zoo.

Parameters:
- Xlen, 32, operand and result width; must be 32 or 64 (check_param_2).
- Func_id_w, 10, function id width; positive (check_param_pos).
- Latency, 2, fixed CXU latency in cycles; must be in [1,8] (check_param_range).
- Depth, 4, response FIFO entries; positive power of two (check_param_pos2exp).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  adapter can accept a request
- req_func  in  Func_id_w  function id
- req_data0  in  Xlen  operand 0
- req_data1  in  Xlen  operand 1
- resp_valid  out  1  response available at FIFO head
- resp_ready  in  1  CPU accepts response
- resp_status  out  Status_w  CX status of head entry
- resp_data  out  Xlen  result of head entry
- cxu_req_valid  out  1  issue to CXU (= req_valid && req_ready)
- cxu_req_func  out  Func_id_w  passthrough of req_func
- cxu_req_data0  out  Xlen  passthrough of req_data0
- cxu_req_data1  out  Xlen  passthrough of req_data1
- cxu_resp_valid  in  1  CXU result valid, exactly Latency cycles after issue
- cxu_resp_status  in  Status_w  CXU status
- cxu_resp_data  in  Xlen  CXU result
- err  out  1  sticky protocol error

Behaviour:
- Reset: credit count, FIFO pointers, in-flight shift register and err all clear. req_ready=0 while rst is high; resp_valid=0, err=0, resp_status/resp_data=0.
- Handshake rule: req_hs = req_valid && req_ready; resp_hs = resp_valid && resp_ready. A valid may not depend on the corresponding ready.
- req_ready = !rst && (credits < Depth).
  - Credits count requests in flight plus entries held in the FIFO.
  - req_ready is combinational from registered state only; it never depends on req_valid.
- Credit update each cycle: +1 on req_hs, -1 on resp_hs, unchanged if both occur. Width is $clog2(Depth)+1 bits; never exceeds Depth and never underflows.
- CXU issue:
  - cxu_req_valid = req_hs, combinational.
  - func/data are pure combinational passthrough.
  - The CXU cannot stall.
- In-flight tracker: a Latency-stage shift register of valid bits. Stage 0 is loaded with req_hs; the last stage gives the expected cxu_resp_valid.
- FIFO write on cxu_resp_valid with {status, data}.
  - Entry visible at the head the next cycle.
  - End-to-end latency: request accepted in cycle t gives resp_valid in cycle t+Latency+1 (if the FIFO was empty).
- FIFO read on resp_hs. Head outputs are registered or come from the memory read of the head pointer, and hold stable while resp_valid && !resp_ready.
- Simultaneous write and read: allowed at any occupancy, including full (the read frees a slot) and empty (the written entry appears next cycle, no same-cycle bypass).
- Wrap-around: pointers are $clog2(Depth)+1 bits. Full/empty is decided by the MSB compare.
- err is set (sticky until rst) on either condition:
  - cxu_resp_valid differs from the tracker's expected bit;
  - a FIFO write arrives while full. Credits should make this unreachable.
- Responses are never dropped, and are delivered in issue order.
- Reset mid-operation: in-flight tracker and FIFO are discarded. Any cxu_resp_valid in the cycle rst is high is ignored. CXU responses arriving after reset deasserts with no tracker bit set raise err.

Decomposition:
- cxu_pkg (imports common_pkg):
  - Status_w=3;
  - typedef enum cx_status_e {CX_OK=0, CX_ERROR_ALL, CX_ERROR_CUSTOM, CX_ERROR_STATE, CX_ERROR_OFF_STATE, CX_ERROR_FUNC, CX_ERROR_OP};
  - typedef resp_t packed {status, data}, parameterized by Xlen via `V.
- Sub-module: sync_fifo (parameters W, Depth; ports clk, rst, wr_v, wr_data, rd_rdy, rd_v, rd_data, full, empty), reused by other zoo blocks.
- Parameter checks run at elaboration via common_pkg check_param_* functions.

Test Plan:
- Single op, Latency=2, Depth=4: req_hs at cycle 10 with func=1, data0=5, data1=7; CXU returns 12/CX_OK at cycle 12 -> resp_valid=1 at cycle 13 with resp_data=12, resp_status=0.
- Back-pressure: resp_ready=0 and 6 requests offered back-to-back -> exactly 4 accepted, req_ready=0 from the 5th cycle on. Then resp_ready=1 -> 4 responses in order; req_ready reasserts the cycle after the first resp_hs.
- Full streaming: req_valid=1 and resp_ready=1 for 100 cycles -> one response per cycle after the Latency+1 fill, credits steady, err=0, data matches the issue sequence.
- Wrap-around: 3×Depth+1 ops with random resp_ready -> all data in order, FIFO pointers wrap without loss.
- Protocol error: inject cxu_resp_valid with no request in flight -> err=1 the next cycle and held until rst.
- Reset mid-flight: pulse rst for 1 cycle with 2 ops in flight and 1 queued -> resp_valid=0, req_ready=1 the cycle after rst deasserts, stale CXU responses set err.
